// File: rtl/boot_overlay.sv
// Boot-ROM overlay for the CPU memory bus.
// Maps one or two address windows onto an external ROM while enabled. A fixed
// LATENCY-deep pipeline returns load data. A store to the disable register
// permanently unmaps the overlay until the next reset.
module boot_overlay #(
    parameter logic [15:0] REGION0_BASE = 16'h0000,
    parameter logic [15:0] REGION0_LAST = 16'h00FF,
    parameter bit          REGION1_EN   = 1'b0,
    parameter logic [15:0] REGION1_BASE = 16'h0200,
    parameter logic [15:0] REGION1_LAST = 16'h08FF,
    parameter logic [15:0] DISABLE_ADDR = 16'hFF50,
    parameter int unsigned ROM_AW       = 12,
    parameter int unsigned LATENCY      = 2
) (
    input  logic              clockgb,
    input  logic              resetn,
    input  logic [15:0]       address,
    input  logic [7:0]        indata,
    input  logic              load,
    input  logic              store,
    output logic [ROM_AW-1:0] rom_address,
    input  logic [7:0]        rom_data,
    output logic [7:0]        outdata,
    output logic              boot_active,
    output logic              boot_enabled
);

    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned DATA_W      = 8;
    localparam logic [15:0] SPAN0       = REGION0_LAST - REGION0_BASE;
    localparam logic [15:0] SPAN1       = REGION1_LAST - REGION1_BASE;
    // Window 1 is packed into the ROM directly after window 0.
    localparam logic [15:0] WIN1_OFFSET = SPAN0 + 16'd1;

    // Reject unsupported configurations at elaboration.
    generate
        if ((LATENCY == 0) || (LATENCY > 4)) begin : g_bad_latency
            $error("boot_overlay: LATENCY must be in 1..4");
        end
        if ((ROM_AW == 0) || (ROM_AW > ADDR_W)) begin : g_bad_rom_aw
            $error("boot_overlay: ROM_AW must be in 1..16");
        end
    endgenerate

    typedef enum logic {
        ST_UNMAPPED = 1'b0,
        ST_MAPPED   = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [ADDR_W:0]   off0;
    logic [ADDR_W:0]   off1;
    logic              hit0;
    logic              hit1;
    logic [ADDR_W-1:0] rom_sel;
    logic              is_disable_addr;

    logic              cap_valid;
    logic [DATA_W-1:0] cap_data;

    logic [LATENCY-1:0] valid_q;
    logic [DATA_W-1:0]  data_q [LATENCY];

    // Only bit 0 of store data is meaningful to the disable register.
    logic unused_indata;
    assign unused_indata = ^indata[7:1];

    // Window decode and ROM address translation; a borrow in the offset means below base.
    always_comb begin
        off0    = {1'b0, address} - {1'b0, REGION0_BASE};
        off1    = {1'b0, address} - {1'b0, REGION1_BASE};
        hit0    = !off0[ADDR_W] && (off0[ADDR_W-1:0] <= SPAN0);
        hit1    = REGION1_EN && !off1[ADDR_W] && (off1[ADDR_W-1:0] <= SPAN1) && !hit0;
        rom_sel = '0;
        if (hit0) begin
            rom_sel = off0[ADDR_W-1:0];
        end else if (hit1) begin
            rom_sel = WIN1_OFFSET + off1[ADDR_W-1:0];
        end
        is_disable_addr = (address == DISABLE_ADDR);
    end

    assign rom_address = rom_sel[ROM_AW-1:0];

    // Stage-1 capture value: disable-register read, window hit, or empty slot.
    always_comb begin
        cap_valid = 1'b0;
        cap_data  = '0;
        if (load && is_disable_addr) begin
            cap_valid = 1'b1;
            cap_data  = {7'h7F, !boot_enabled};
        end else if (load && boot_enabled && (hit0 || hit1)) begin
            cap_valid = 1'b1;
            cap_data  = rom_data;
        end
    end

    // Mapping state register.
    always_ff @(posedge clockgb or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_MAPPED;
        end else begin
            state_q <= state_d;
        end
    end

    // Next mapping state: a store with bit 0 set at the disable register unmaps for good.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_MAPPED: begin
                if (store && is_disable_addr && indata[0]) begin
                    state_d = ST_UNMAPPED;
                end
            end
            ST_UNMAPPED: begin
                state_d = ST_UNMAPPED;
            end
            default: begin
                state_d = ST_MAPPED;
            end
        endcase
    end

    assign boot_enabled = (state_q == ST_MAPPED);

    // Load pipeline: stage 0 captures, all stages shift every cycle.
    always_ff @(posedge clockgb or negedge resetn) begin
        if (!resetn) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= cap_valid;
            data_q[0]  <= cap_data;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    // Empty slots carry zero data, so the last stage drives the bus directly.
    assign boot_active = valid_q[LATENCY-1];
    assign outdata     = data_q[LATENCY-1];

endmodule

// File: tb/tb_boot_overlay.sv
// Directed bench for boot_overlay: a two-window CGB-style instance (LATENCY=2)
// and a default DMG-style instance (LATENCY=4) share the CPU bus stimulus.
module tb_boot_overlay;

    logic        clockgb;
    logic        resetn;
    logic [15:0] address;
    logic [7:0]  indata;
    logic        load;
    logic        store;

    logic [11:0] rom_address_a;
    logic [7:0]  rom_data_a;
    logic [7:0]  outdata_a;
    logic        boot_active_a;
    logic        boot_enabled_a;

    logic [11:0] rom_address_b;
    logic [7:0]  rom_data_b;
    logic [7:0]  outdata_b;
    logic        boot_active_b;
    logic        boot_enabled_b;

    int n_cmp;
    int n_fail;

    boot_overlay #(
        .REGION1_EN (1'b1),
        .LATENCY    (2)
    ) dut_a (
        .clockgb      (clockgb),
        .resetn       (resetn),
        .address      (address),
        .indata       (indata),
        .load         (load),
        .store        (store),
        .rom_address  (rom_address_a),
        .rom_data     (rom_data_a),
        .outdata      (outdata_a),
        .boot_active  (boot_active_a),
        .boot_enabled (boot_enabled_a)
    );

    boot_overlay #(
        .LATENCY (4)
    ) dut_b (
        .clockgb      (clockgb),
        .resetn       (resetn),
        .address      (address),
        .indata       (indata),
        .load         (load),
        .store        (store),
        .rom_address  (rom_address_b),
        .rom_data     (rom_data_b),
        .outdata      (outdata_b),
        .boot_active  (boot_active_b),
        .boot_enabled (boot_enabled_b)
    );

    // ROM image: 8'h31 ^ a[7:0] ^ a[11:8].
    function automatic logic [7:0] rom_img(input logic [11:0] a);
        return 8'h31 ^ a[7:0] ^ {4'h0, a[11:8]};
    endfunction

    always_comb rom_data_a = rom_img(rom_address_a);
    always_comb rom_data_b = rom_img(rom_address_b);

    initial clockgb = 1'b0;
    always #5 clockgb = ~clockgb;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clockgb);
        #1;
    endtask

    task automatic idle;
        load    = 1'b0;
        store   = 1'b0;
        address = 16'hC000;
        indata  = 8'h00;
    endtask

    task automatic ld(input logic [15:0] a);
        load    = 1'b1;
        store   = 1'b0;
        address = a;
        indata  = 8'h00;
    endtask

    task automatic st(input logic [15:0] a, input logic [7:0] d);
        load    = 1'b0;
        store   = 1'b1;
        address = a;
        indata  = d;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        resetn = 1'b0;
        idle();
        #12;
        chk("rst_enabled_a", 16'(boot_enabled_a), 16'h1);
        chk("rst_active_a",  16'(boot_active_a),  16'h0);
        chk("rst_out_a",     16'(outdata_a),      16'h00);
        chk("rst_enabled_b", 16'(boot_enabled_b), 16'h1);
        chk("rst_active_b",  16'(boot_active_b),  16'h0);
        @(posedge clockgb);
        #1;
        resetn = 1'b1;
        tick();

        // Basic load at 0000, two-cycle latency, single-cycle result.
        ld(16'h0000);
        #1;
        chk("t1_rom_addr", 16'(rom_address_a), 16'h000);
        tick();
        idle();
        chk("t1_not_yet", 16'(boot_active_a), 16'h0);
        tick();
        chk("t1_active", 16'(boot_active_a), 16'h1);
        chk("t1_data",   16'(outdata_a),     16'h31);
        tick();
        chk("t1_drop_active", 16'(boot_active_a), 16'h0);
        chk("t1_drop_data",   16'(outdata_a),     16'h00);

        // Window 1 mapping and edges, back to back.
        ld(16'h0200);
        #1;
        chk("t2_rom_0200",   16'(rom_address_a), 16'h100);
        chk("t2_rom_b_0200", 16'(rom_address_b), 16'h000);
        tick();
        ld(16'h08FF);
        #1;
        chk("t2_rom_08ff", 16'(rom_address_a), 16'h7FF);
        tick();
        chk("t2_act_0200",  16'(boot_active_a), 16'h1);
        chk("t2_data_0200", 16'(outdata_a),     16'h30);
        ld(16'h0100);
        #1;
        chk("t2_rom_0100", 16'(rom_address_a), 16'h000);
        tick();
        chk("t2_act_08ff",  16'(boot_active_a), 16'h1);
        chk("t2_data_08ff", 16'(outdata_a),     16'hC9);
        ld(16'h0900);
        #1;
        chk("t2_rom_0900", 16'(rom_address_a), 16'h000);
        tick();
        chk("t2_act_0100",  16'(boot_active_a), 16'h0);
        chk("t2_data_0100", 16'(outdata_a),     16'h00);
        idle();
        tick();
        chk("t2_act_0900", 16'(boot_active_a), 16'h0);

        // Window 0 top boundary on consecutive cycles.
        ld(16'h00FE);
        tick();
        ld(16'h00FF);
        #1;
        chk("t3_rom_b_00ff", 16'(rom_address_b), 16'h0FF);
        tick();
        chk("t3_act_00fe",  16'(boot_active_a), 16'h1);
        chk("t3_data_00fe", 16'(outdata_a),     16'hCF);
        ld(16'h0100);
        tick();
        chk("t3_act_00ff",  16'(boot_active_a), 16'h1);
        chk("t3_data_00ff", 16'(outdata_a),     16'hCE);
        ld(16'hFFFF);
        #1;
        chk("t3_rom_ffff", 16'(rom_address_a), 16'h000);
        tick();
        chk("t3_act_0100", 16'(boot_active_a), 16'h0);
        idle();
        tick();
        chk("t3_act_ffff", 16'(boot_active_a), 16'h0);

        // Disable register read, ignored and effective stores.
        ld(16'hFF50);
        tick();
        idle();
        tick();
        chk("t4_act_ff50_en",  16'(boot_active_a), 16'h1);
        chk("t4_data_ff50_en", 16'(outdata_a),     16'hFE);
        st(16'hFF50, 8'h00);
        tick();
        chk("t4_still_en", 16'(boot_enabled_a), 16'h1);
        st(16'hFF50, 8'h01);
        tick();
        chk("t4_dis_a", 16'(boot_enabled_a), 16'h0);
        chk("t4_dis_b", 16'(boot_enabled_b), 16'h0);
        ld(16'hFF50);
        tick();
        ld(16'h0000);
        tick();
        chk("t4_act_ff50_dis",  16'(boot_active_a), 16'h1);
        chk("t4_data_ff50_dis", 16'(outdata_a),     16'hFF);
        idle();
        tick();
        chk("t4_act_0000_dis",  16'(boot_active_a), 16'h0);
        chk("t4_data_0000_dis", 16'(outdata_a),     16'h00);
        st(16'hFF50, 8'h00);
        tick();
        chk("t4_stays_dis", 16'(boot_enabled_a), 16'h0);
        idle();

        // Load in flight across the disable edge completes; later load misses.
        resetn = 1'b0;
        #1;
        chk("t5_rst_reenable", 16'(boot_enabled_a), 16'h1);
        tick();
        resetn = 1'b1;
        tick();
        ld(16'h0010);
        tick();
        st(16'hFF50, 8'h01);
        tick();
        chk("t5_act_0010",  16'(boot_active_a),  16'h1);
        chk("t5_data_0010", 16'(outdata_a),      16'h21);
        chk("t5_dis",       16'(boot_enabled_a), 16'h0);
        ld(16'h0000);
        tick();
        idle();
        tick();
        chk("t5_act_after", 16'(boot_active_a), 16'h0);

        // Reset in the middle of loads discards them.
        resetn = 1'b0;
        #1;
        tick();
        resetn = 1'b1;
        tick();
        ld(16'h0000);
        tick();
        idle();
        tick();
        chk("t6_act_a_pre", 16'(boot_active_a), 16'h1);
        chk("t6_data_a_pre", 16'(outdata_a),    16'h31);
        resetn = 1'b0;
        #1;
        chk("t6_rst_act_a",  16'(boot_active_a), 16'h0);
        chk("t6_rst_data_a", 16'(outdata_a),     16'h00);
        chk("t6_rst_act_b",  16'(boot_active_b), 16'h0);
        chk("t6_rst_data_b", 16'(outdata_b),     16'h00);
        tick();
        resetn = 1'b1;
        tick();
        chk("t6_flush_b_1", 16'(boot_active_b), 16'h0);
        tick();
        chk("t6_flush_b_2", 16'(boot_active_b), 16'h0);
        chk("t6_en_b", 16'(boot_enabled_b), 16'h1);
        ld(16'h0000);
        tick();
        idle();
        chk("t6_lat_b_1", 16'(boot_active_b), 16'h0);
        tick();
        chk("t6_lat_b_2", 16'(boot_active_b), 16'h0);
        tick();
        chk("t6_lat_b_3", 16'(boot_active_b), 16'h0);
        tick();
        chk("t6_act_b",  16'(boot_active_b), 16'h1);
        chk("t6_data_b", 16'(outdata_b),     16'h31);
        tick();
        chk("t6_drop_b", 16'(boot_active_b), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
